// File: rtl/vga_pkg.sv
// Shared VGA/VRAM definitions: memory geometry, 800x600@60 timing, CPU port FSM encoding.
package vga_pkg;

  localparam int VRAM_ADDR_W = 15;
  localparam int VRAM_DATA_W = 8;

  // 800x600 @ 60 Hz with a 40 MHz pixel clock
  localparam int H_VISIBLE = 800;
  localparam int H_FRONT   = 40;
  localparam int H_SYNC    = 128;
  localparam int H_BACK    = 88;
  localparam int H_TOTAL   = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_VISIBLE = 600;
  localparam int V_FRONT   = 1;
  localparam int V_SYNC    = 4;
  localparam int V_BACK    = 23;
  localparam int V_TOTAL   = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  typedef enum logic [1:0] {
    C_IDLE = 2'd0,
    C_WAIT = 2'd1,
    C_HOLD = 2'd2
  } cpu_state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear; flags when the limit is reached.
module sat_counter
  import vga_pkg::*;
#(
  parameter int WIDTH = 3,
  parameter int LIMIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clr,
  output logic at_limit
);

  localparam logic [WIDTH-1:0] LIMIT_V = WIDTH'(LIMIT);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  // Clear wins over increment
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT_V)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign at_limit = (cnt_q == LIMIT_V);

endmodule

// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display scanout has priority, CPU gets a bounded-wait slot.
module vram_arbiter
  import vga_pkg::*;
#(
  parameter int ADDR_W       = VRAM_ADDR_W,
  parameter int DATA_W       = VRAM_DATA_W,
  parameter int STARVE_LIMIT = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              disp_req,
  input  logic [ADDR_W-1:0] disp_addr,
  output logic              disp_ack,
  output logic              disp_rvalid,
  output logic [DATA_W-1:0] disp_rdata,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_ack,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);

  cpu_state_e        cpu_state_q, cpu_state_d;
  logic              disp_ack_q, disp_ack_d;
  logic              cpu_ack_q, cpu_ack_d;
  logic              mem_en_q, mem_en_d;
  logic              mem_we_q, mem_we_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [1:0]        tag_q, tag_d;
  logic [1:0]        rvalid_q, rvalid_d;
  logic [DATA_W-1:0] disp_hold_q, disp_hold_d;
  logic [DATA_W-1:0] cpu_hold_q, cpu_hold_d;

  logic cpu_pending;
  logic cpu_grant;
  logic disp_grant;
  logic starve_inc;
  logic starve_clr;
  logic starved;

  sat_counter #(
    .WIDTH (CNT_W),
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .inc      (starve_inc),
    .clr      (starve_clr),
    .at_limit (starved)
  );

  // Grant decision; the CPU request is ignored while its access is being acked
  always_comb begin
    cpu_pending = cpu_req && (cpu_state_q != C_HOLD);
    cpu_grant   = cpu_pending && (!disp_req || starved);
    disp_grant  = disp_req && !cpu_grant;
    starve_inc  = (cpu_state_q == C_WAIT) && cpu_req && disp_grant;
    starve_clr  = cpu_grant || !cpu_req;

    disp_ack_d  = disp_grant;
    cpu_ack_d   = cpu_grant;
    mem_en_d    = disp_grant || cpu_grant;
    mem_we_d    = cpu_grant && cpu_we;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    if (cpu_grant) begin
      mem_addr_d = cpu_addr;
      if (cpu_we) begin
        mem_wdata_d = cpu_wdata;
      end
    end else if (disp_grant) begin
      mem_addr_d = disp_addr;
    end

    tag_d       = {disp_grant, cpu_grant && !cpu_we};
    rvalid_d    = tag_q;
    disp_hold_d = rvalid_q[1] ? mem_rdata : disp_hold_q;
    cpu_hold_d  = rvalid_q[0] ? mem_rdata : cpu_hold_q;
  end

  always_comb begin
    cpu_state_d = cpu_state_q;
    case (cpu_state_q)
      C_IDLE: if (cpu_req) cpu_state_d = cpu_grant ? C_HOLD : C_WAIT;
      C_WAIT: begin
        if (!cpu_req) begin
          cpu_state_d = C_IDLE;
        end else if (cpu_grant) begin
          cpu_state_d = C_HOLD;
        end
      end
      C_HOLD:  cpu_state_d = C_IDLE;
      default: cpu_state_d = C_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cpu_state_q <= C_IDLE;
      disp_ack_q  <= 1'b0;
      cpu_ack_q   <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      tag_q       <= '0;
      rvalid_q    <= '0;
      disp_hold_q <= '0;
      cpu_hold_q  <= '0;
    end else begin
      cpu_state_q <= cpu_state_d;
      disp_ack_q  <= disp_ack_d;
      cpu_ack_q   <= cpu_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      tag_q       <= tag_d;
      rvalid_q    <= rvalid_d;
      disp_hold_q <= disp_hold_d;
      cpu_hold_q  <= cpu_hold_d;
    end
  end

  // RAM data arrives the cycle after the access, so it is forwarded straight through
  assign disp_ack    = disp_ack_q;
  assign cpu_ack     = cpu_ack_q;
  assign mem_en      = mem_en_q;
  assign mem_we      = mem_we_q;
  assign mem_addr    = mem_addr_q;
  assign mem_wdata   = mem_wdata_q;
  assign disp_rvalid = rvalid_q[1];
  assign cpu_rvalid  = rvalid_q[0];
  assign disp_rdata  = rvalid_q[1] ? mem_rdata : disp_hold_q;
  assign cpu_rdata   = rvalid_q[0] ? mem_rdata : cpu_hold_q;

endmodule

// File: tb/tb_vram_arbiter.sv
// Directed vector table plus a scoreboarded random phase for vram_arbiter.
module tb_vram_arbiter;

  localparam int STARVE_LIMIT = 4;

  typedef struct {
    string       name;
    logic        rst_n;
    logic        disp_req;
    logic [14:0] disp_addr;
    logic        cpu_req;
    logic        cpu_we;
    logic [14:0] cpu_addr;
    logic [7:0]  cpu_wdata;
    logic [44:0] exp;
  } vec_t;

  logic        clk;
  logic        rst_n;
  logic        disp_req;
  logic [14:0] disp_addr;
  logic        disp_ack;
  logic        disp_rvalid;
  logic [7:0]  disp_rdata;
  logic        cpu_req;
  logic        cpu_we;
  logic [14:0] cpu_addr;
  logic [7:0]  cpu_wdata;
  logic        cpu_ack;
  logic        cpu_rvalid;
  logic [7:0]  cpu_rdata;
  logic        mem_en;
  logic        mem_we;
  logic [14:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  ram [0:32767];
  logic [7:0]  shadow [0:32767];
  logic        ram_init;
  int          checks;
  int          errors;
  vec_t        vecs[$];

  vram_arbiter #(
    .ADDR_W       (15),
    .DATA_W       (8),
    .STARVE_LIMIT (STARVE_LIMIT)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .disp_req    (disp_req),
    .disp_addr   (disp_addr),
    .disp_ack    (disp_ack),
    .disp_rvalid (disp_rvalid),
    .disp_rdata  (disp_rdata),
    .cpu_req     (cpu_req),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wdata   (cpu_wdata),
    .cpu_ack     (cpu_ack),
    .cpu_rvalid  (cpu_rvalid),
    .cpu_rdata   (cpu_rdata),
    .mem_en      (mem_en),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous RAM, one-cycle read latency, preloaded with a[i] = i ^ 5A
  always @(posedge clk) begin
    if (ram_init) begin
      for (int i = 0; i < 32768; i++) ram[i] <= 8'(i) ^ 8'h5A;
      mem_rdata <= 8'h00;
    end else if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  function automatic vec_t vec(string n, int r, int dr, int da, int cr, int cw, int ca, int cwd,
                               int eda, int edv, int edd, int eca, int ecv, int ecd,
                               int me, int mw, int ma, int mwd);
    vec_t t;
    t.name      = n;
    t.rst_n     = 1'(r);
    t.disp_req  = 1'(dr);
    t.disp_addr = 15'(da);
    t.cpu_req   = 1'(cr);
    t.cpu_we    = 1'(cw);
    t.cpu_addr  = 15'(ca);
    t.cpu_wdata = 8'(cwd);
    t.exp = {1'(eda), 1'(edv), 8'(edd), 1'(eca), 1'(ecv), 8'(ecd),
             1'(me), 1'(mw), 15'(ma), 8'(mwd)};
    return t;
  endfunction

  task automatic applyStimulus(input vec_t t);
    rst_n     = t.rst_n;
    disp_req  = t.disp_req;
    disp_addr = t.disp_addr;
    cpu_req   = t.cpu_req;
    cpu_we    = t.cpu_we;
    cpu_addr  = t.cpu_addr;
    cpu_wdata = t.cpu_wdata;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic checkOutput(input vec_t t);
    logic [44:0] act;
    act = {disp_ack, disp_rvalid, disp_rdata, cpu_ack, cpu_rvalid, cpu_rdata,
           mem_en, mem_we, mem_addr, mem_wdata};
    checks++;
    if (act !== t.exp) begin
      errors++;
      $display("[TB] FAIL %s: outputs got %h want %h", t.name, act, t.exp);
    end
  endtask

  task automatic flag(input string n, input int got, input int want);
    errors++;
    $display("[TB] FAIL %s: got %0h want %0h", n, got, want);
  endtask

  initial begin
    logic       exp_drv, exp_crv;
    logic [7:0] exp_dd, exp_cd;
    int         cpu_wait;

    checks   = 0;
    errors   = 0;
    ram_init = 1'b1;
    for (int i = 0; i < 32768; i++) shadow[i] = 8'(i) ^ 8'h5A;

    //                name          r dr da    cr cw ca     cwd    eda edv edd  eca ecv ecd  me mw ma     mwd
    vecs.push_back(vec("reset0",     0,0,'h00, 0,0,'h000,'h00,  0,0,'h00, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("reset1",     0,0,'h00, 0,0,'h000,'h00,  0,0,'h00, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t1_a0",      1,1,'h00, 0,0,'h000,'h00,  1,0,'h00, 0,0,'h00, 1,0,'h000,'h00));
    vecs.push_back(vec("t1_a1",      1,1,'h01, 0,0,'h000,'h00,  1,1,'h5A, 0,0,'h00, 1,0,'h001,'h00));
    vecs.push_back(vec("t1_a2",      1,1,'h02, 0,0,'h000,'h00,  1,1,'h5B, 0,0,'h00, 1,0,'h002,'h00));
    vecs.push_back(vec("t1_a3",      1,1,'h03, 0,0,'h000,'h00,  1,1,'h58, 0,0,'h00, 1,0,'h003,'h00));
    vecs.push_back(vec("t1_end",     1,0,'h00, 0,0,'h000,'h00,  0,1,'h59, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t1_hold",    1,0,'h00, 0,0,'h000,'h00,  0,0,'h59, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t2_wr",      1,0,'h00, 1,1,'h100,'hC3,  0,0,'h59, 1,0,'h00, 1,1,'h100,'hC3));
    vecs.push_back(vec("t2_nodup",   1,0,'h00, 1,1,'h100,'hC3,  0,0,'h59, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t2_idle",    1,0,'h00, 0,0,'h000,'h00,  0,0,'h59, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t3_rd",      1,0,'h00, 1,0,'h100,'h00,  0,0,'h59, 1,0,'h00, 1,0,'h100,'h00));
    vecs.push_back(vec("t3_rvalid",  1,0,'h00, 0,0,'h000,'h00,  0,0,'h59, 0,1,'hC3, 0,0,'h000,'h00));
    vecs.push_back(vec("t3_hold",    1,0,'h00, 0,0,'h000,'h00,  0,0,'h59, 0,0,'hC3, 0,0,'h000,'h00));
    vecs.push_back(vec("t4_c0",      1,1,'h10, 1,0,'h100,'h00,  1,0,'h59, 0,0,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_c1",      1,1,'h10, 1,0,'h100,'h00,  1,1,'h4A, 0,0,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_c2",      1,1,'h10, 1,0,'h100,'h00,  1,1,'h4A, 0,0,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_c3",      1,1,'h10, 1,0,'h100,'h00,  1,1,'h4A, 0,0,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_c4",      1,1,'h10, 1,0,'h100,'h00,  1,1,'h4A, 0,0,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_grant",   1,1,'h10, 1,0,'h100,'h00,  0,1,'h4A, 1,0,'hC3, 1,0,'h100,'h00));
    vecs.push_back(vec("t4_resume",  1,1,'h10, 1,0,'h100,'h00,  1,0,'h4A, 0,1,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_after",   1,1,'h10, 0,0,'h000,'h00,  1,1,'h4A, 0,0,'hC3, 1,0,'h010,'h00));
    vecs.push_back(vec("t4_drain",   1,0,'h00, 0,0,'h000,'h00,  0,1,'h4A, 0,0,'hC3, 0,0,'h000,'h00));
    vecs.push_back(vec("t4_idle",    1,0,'h00, 0,0,'h000,'h00,  0,0,'h4A, 0,0,'hC3, 0,0,'h000,'h00));
    vecs.push_back(vec("t5_issue",   1,1,'h05, 0,0,'h000,'h00,  1,0,'h4A, 0,0,'hC3, 1,0,'h005,'h00));
    vecs.push_back(vec("t5_reset",   0,0,'h00, 0,0,'h000,'h00,  0,0,'h00, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t5_release", 1,0,'h00, 0,0,'h000,'h00,  0,0,'h00, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("t5_first",   1,1,'h06, 0,0,'h000,'h00,  1,0,'h00, 0,0,'h00, 1,0,'h006,'h00));
    vecs.push_back(vec("t5_data",    1,0,'h00, 0,0,'h000,'h00,  0,1,'h5C, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("drop_wait",  1,1,'h07, 1,1,'h200,'hAA,  1,0,'h5C, 0,0,'h00, 1,0,'h007,'h00));
    vecs.push_back(vec("drop_gone",  1,1,'h07, 0,0,'h000,'h00,  1,1,'h5D, 0,0,'h00, 1,0,'h007,'h00));
    vecs.push_back(vec("drop_drain", 1,0,'h00, 0,0,'h000,'h00,  0,1,'h5D, 0,0,'h00, 0,0,'h000,'h00));
    vecs.push_back(vec("drop_idle",  1,0,'h00, 0,0,'h000,'h00,  0,0,'h5D, 0,0,'h00, 0,0,'h000,'h00));

    for (int i = 0; i < vecs.size(); i++) begin
      applyStimulus(vecs[i]);
      ram_init = 1'b0;
      checkOutput(vecs[i]);
    end
    shadow[15'h100] = 8'hC3;

    // Random traffic: CPU follows the hold-until-ack protocol, display streams freely
    $display("[TB] random phase");
    exp_drv  = 1'b0;
    exp_crv  = 1'b0;
    exp_dd   = 8'h00;
    exp_cd   = 8'h00;
    cpu_wait = 0;
    for (int c = 0; c < 10000; c++) begin
      @(posedge clk);
      @(negedge clk);
      checks++;
      if (disp_ack && cpu_ack) flag("ack_mutex", 32'({disp_ack, cpu_ack}), 2);
      checks++;
      if (mem_en !== (disp_ack | cpu_ack)) flag("mem_en", 32'(mem_en), 32'(disp_ack | cpu_ack));
      checks++;
      if (disp_rvalid !== exp_drv || (exp_drv && disp_rdata !== exp_dd))
        flag("disp_read", 32'({disp_rvalid, disp_rdata}), 32'({exp_drv, exp_dd}));
      checks++;
      if (cpu_rvalid !== exp_crv || (exp_crv && cpu_rdata !== exp_cd))
        flag("cpu_read", 32'({cpu_rvalid, cpu_rdata}), 32'({exp_crv, exp_cd}));
      exp_drv = 1'b0;
      exp_crv = 1'b0;
      if (disp_ack) begin
        checks++;
        if (!disp_req || mem_addr !== disp_addr || mem_we)
          flag("disp_issue", 32'({mem_we, mem_addr}), 32'({1'b0, disp_addr}));
        exp_drv = 1'b1;
        exp_dd  = shadow[disp_addr];
      end
      if (cpu_ack) begin
        checks++;
        if (!cpu_req || mem_addr !== cpu_addr || mem_we !== cpu_we ||
            (cpu_we && mem_wdata !== cpu_wdata) || cpu_wait > STARVE_LIMIT + 1)
          flag("cpu_issue", 32'({cpu_wait[3:0], mem_we, mem_addr}), 32'({4'd0, cpu_we, cpu_addr}));
        if (cpu_we) begin
          shadow[cpu_addr] = cpu_wdata;
        end else begin
          exp_crv = 1'b1;
          exp_cd  = shadow[cpu_addr];
        end
        cpu_req = 1'b0;
      end else if (cpu_req) begin
        cpu_wait++;
        if (cpu_wait > STARVE_LIMIT + 2) begin
          checks++;
          flag("cpu_timeout", cpu_wait, STARVE_LIMIT + 1);
          cpu_req = 1'b0;
        end
      end else if ($urandom_range(0, 3) == 0) begin
        cpu_req   = 1'b1;
        cpu_we    = 1'($urandom_range(0, 1));
        cpu_addr  = 15'($urandom_range(0, 63));
        cpu_wdata = 8'($urandom);
        cpu_wait  = 0;
      end
      disp_req  = ($urandom_range(0, 9) < 7);
      disp_addr = 15'($urandom_range(0, 63));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
